// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiplier result path: FSM encodings,
// framing constants, default dimensions and the element-index helper.
package matmul_pkg;

    localparam int N_DIM_DEF  = 3;
    localparam int ELEM_W_DEF = 16;
    localparam int ACK_TO_DEF = 15;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Sequencer states; the byte handshake itself lives in tx_byte_handshake
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SEND   = 3'd2;
    localparam logic [2:0] ST_NEXT   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam logic [1:0] HS_IDLE      = 2'd0;
    localparam logic [1:0] HS_ISSUE     = 2'd1;
    localparam logic [1:0] HS_WAIT_ACK  = 2'd2;
    localparam logic [1:0] HS_WAIT_DONE = 2'd3;

    // Which kind of byte is currently being moved (header, payload, checksum)
    localparam logic [1:0] PH_HDR0 = 2'd0;
    localparam logic [1:0] PH_HDR1 = 2'd1;
    localparam logic [1:0] PH_PAY  = 2'd2;
    localparam logic [1:0] PH_CHK  = 2'd3;

    function automatic logic [31:0] elem_idx(input logic [31:0] r,
                                             input logic [31:0] c,
                                             input logic [31:0] n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/tx_byte_handshake.sv
// Moves one byte into uart_tx via start/busy: ISSUE, WAIT_ACK (with retry
// timeout) and WAIT_DONE. One-cycle o_ack when the byte has left uart_tx.
module tx_byte_handshake import matmul_pkg::*; #(
    parameter int ACK_TO = ACK_TO_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req,
    input  logic [7:0] i_byte,
    input  logic       i_tx_busy,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_ack
);
    localparam int               CNT_W    = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TO - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_tx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= HS_IDLE;
            r_cnt     <= '0;
            r_tx_data <= '0;
        end else begin
            case (r_state)
                HS_IDLE: begin
                    if (i_req) begin
                        r_state   <= HS_ISSUE;
                        r_tx_data <= i_byte;
                    end
                end
                HS_ISSUE: begin
                    r_state <= HS_WAIT_ACK;
                    r_cnt   <= '0;
                end
                HS_WAIT_ACK: begin
                    // Unanswered request is re-issued with the same byte
                    if (i_tx_busy)
                        r_state <= HS_WAIT_DONE;
                    else if (r_cnt == CNT_LAST)
                        r_state <= HS_ISSUE;
                    else
                        r_cnt <= r_cnt + 1'b1;
                end
                HS_WAIT_DONE: begin
                    if (!i_tx_busy)
                        r_state <= HS_IDLE;
                end
                default: r_state <= HS_IDLE;
            endcase
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_start = (r_state == HS_ISSUE);
    assign o_ack      = (r_state == HS_WAIT_DONE) && !i_tx_busy;

endmodule

// File: rtl/matmul_result_tx.sv
// Serializes the active size x size corner of the product matrix into uart_tx,
// row-major, MSB byte first. MATMUL_RESULT_TX_FRAME_EN adds header and XOR trailer.
module matmul_result_tx import matmul_pkg::*; #(
    parameter int N_DIM  = N_DIM_DEF,
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int ACK_TO = ACK_TO_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [N_DIM*N_DIM*ELEM_W-1:0] result,
    input  logic [3:0]                    matrix_size,
    input  logic                          tx_busy,
    output logic [7:0]                    tx_data,
    output logic                          tx_start,
    output logic                          busy,
    output logic                          done,
    output logic                          size_err
);
    localparam int         RES_W     = N_DIM * N_DIM * ELEM_W;
    localparam logic [3:0] SIZE_MAX  = 4'(N_DIM);
    localparam logic [3:0] BYTE_LAST = 4'(ELEM_W / 8 - 1);

    logic [2:0]        r_state, w_next_state;
    logic [1:0]        r_phase, w_req_phase;
    logic [RES_W-1:0]  r_result;
    logic [3:0]        r_size, r_row, r_col, r_byte;
    logic              r_size_err;
    logic              w_accept, w_size_ok, w_pay_end, w_req, w_ack;
    logic [ELEM_W-1:0] w_elem;
    logic [7:0]        w_pay_byte, w_req_byte;
`ifdef MATMUL_RESULT_TX_FRAME_EN
    logic [7:0]        r_chk;
`endif

    // A start landing on the FINISH cycle is accepted as well, since busy is already low there
    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_FINISH));
    assign w_size_ok  = (r_size != 4'd0) && (r_size <= SIZE_MAX);
    assign w_pay_end  = (r_row == r_size);
    assign w_elem     = ELEM_W'(r_result >> (elem_idx(32'(r_row), 32'(r_col), N_DIM) * ELEM_W));
    assign w_pay_byte = 8'(w_elem >> (32'(BYTE_LAST - r_byte) * 8));

    always_comb begin
        w_req_byte = w_pay_byte;
`ifdef MATMUL_RESULT_TX_FRAME_EN
        case (w_req_phase)
            PH_HDR0: w_req_byte = SYNC_BYTE;
            PH_HDR1: w_req_byte = {4'h0, r_size};
            PH_CHK:  w_req_byte = r_chk;
            default: w_req_byte = w_pay_byte;
        endcase
`endif
    end

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_req_phase  = r_phase;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
`ifdef MATMUL_RESULT_TX_FRAME_EN
                w_req        = 1'b1;
                w_req_phase  = PH_HDR0;
                w_next_state = ST_SEND;
`else
                if (w_size_ok) begin
                    w_req        = 1'b1;
                    w_req_phase  = PH_PAY;
                    w_next_state = ST_SEND;
                end else begin
                    w_next_state = ST_FINISH;
                end
`endif
            end
            ST_SEND: begin
                if (w_ack)
                    w_next_state = ST_NEXT;
            end
            ST_NEXT: begin
                w_next_state = ST_FINISH;
                case (r_phase)
`ifdef MATMUL_RESULT_TX_FRAME_EN
                    PH_HDR0: begin
                        w_req        = 1'b1;
                        w_req_phase  = PH_HDR1;
                        w_next_state = ST_SEND;
                    end
                    PH_HDR1: begin
                        if (!r_size_err) begin
                            w_req        = 1'b1;
                            w_req_phase  = PH_PAY;
                            w_next_state = ST_SEND;
                        end
                    end
`endif
                    PH_PAY: begin
`ifdef MATMUL_RESULT_TX_FRAME_EN
                        w_req        = 1'b1;
                        w_req_phase  = w_pay_end ? PH_CHK : PH_PAY;
                        w_next_state = ST_SEND;
`else
                        if (!w_pay_end) begin
                            w_req        = 1'b1;
                            w_next_state = ST_SEND;
                        end
`endif
                    end
                    default: w_next_state = ST_FINISH;
                endcase
            end
            ST_FINISH: begin
                w_next_state = start ? ST_LOAD : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_phase    <= PH_HDR0;
            r_size     <= '0;
            r_size_err <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_byte     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_req)
                r_phase <= w_req_phase;
            if (w_accept) begin
                r_size     <= matrix_size;
                r_size_err <= 1'b0;
                r_row      <= '0;
                r_col      <= '0;
                r_byte     <= '0;
            end
            if ((r_state == ST_LOAD) && !w_size_ok)
                r_size_err <= 1'b1;
            // Cursor moves once a payload byte is done; row == size marks the end
            if ((r_state == ST_SEND) && w_ack && (r_phase == PH_PAY)) begin
                if (r_byte == BYTE_LAST) begin
                    r_byte <= '0;
                    if (r_col == r_size - 4'd1) begin
                        r_col <= '0;
                        r_row <= r_row + 4'd1;
                    end else begin
                        r_col <= r_col + 4'd1;
                    end
                end else begin
                    r_byte <= r_byte + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_result <= result;
    end

`ifdef MATMUL_RESULT_TX_FRAME_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_chk <= '0;
        else if (w_accept)
            r_chk <= '0;
        else if (w_req && (w_req_phase == PH_PAY))
            r_chk <= r_chk ^ w_req_byte;
    end
`endif

    tx_byte_handshake #(
        .ACK_TO(ACK_TO)
    ) u_hs (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_req),
        .i_byte    (w_req_byte),
        .i_tx_busy (tx_busy),
        .o_tx_data (tx_data),
        .o_tx_start(tx_start),
        .o_ack     (w_ack)
    );

    assign busy     = (r_state != ST_IDLE) && (r_state != ST_FINISH);
    assign done     = (r_state == ST_FINISH);
    assign size_err = r_size_err;

endmodule

// File: tb/tb_matmul_result_tx.sv
// Bench for matmul_result_tx: uart_tx responder, byte-stream reference model
// built from the element matrix, directed and randomized sequences.
module tb_matmul_result_tx;
    localparam int N      = 3;
    localparam int W      = 16;
    localparam int ACK_TO = 15;
    localparam int BUDGET = 3000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [N*N*W-1:0] result;
    logic [3:0]       matrix_size;
    logic             tx_busy = 1'b0;
    logic [7:0]       tx_data;
    logic             tx_start;
    logic             busy;
    logic             done;
    logic             size_err;

    matmul_result_tx #(.N_DIM(N), .ELEM_W(W), .ACK_TO(ACK_TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .result     (result),
        .matrix_size(matrix_size),
        .tx_busy    (tx_busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .busy       (busy),
        .done       (done),
        .size_err   (size_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;

    // uart_tx responder and protocol monitor state (owned by the always block)
    logic       clr = 1'b0;
    int         busy_len = 1;
    int         ign_limit = 0;
    int         ign_cnt = 0;
    int         busy_cnt = 0;
    logic [7:0] held = 8'h00;
    logic       prev_start = 1'b0;
    logic       prev_done = 1'b0;
    int         pulse_viol = 0;
    int         stable_viol = 0;
    int         done_viol = 0;
    logic [7:0] rx_q[$];
    logic [7:0] sd_q[$];
    int         st_q[$];

    logic [15:0] elem [N][N];
    logic [7:0]  exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clr) begin
            rx_q.delete();
            sd_q.delete();
            st_q.delete();
            ign_cnt     <= ign_limit;
            pulse_viol  <= 0;
            stable_viol <= 0;
            done_viol   <= 0;
        end else begin
            if (tx_start) begin
                st_q.push_back(cyc);
                sd_q.push_back(tx_data);
            end
            if (tx_start && prev_start) pulse_viol <= pulse_viol + 1;
            if (tx_busy && (tx_data !== held)) stable_viol <= stable_viol + 1;
            if (done && (busy || prev_done)) done_viol <= done_viol + 1;
        end
        prev_start <= tx_start;
        prev_done  <= done;
        if (tx_busy) begin
            if (busy_cnt <= 1) tx_busy <= 1'b0;
            busy_cnt <= busy_cnt - 1;
        end else if (tx_start && !clr) begin
            if (ign_cnt > 0) begin
                ign_cnt <= ign_cnt - 1;
            end else begin
                rx_q.push_back(tx_data);
                held     <= tx_data;
                tx_busy  <= 1'b1;
                busy_cnt <= busy_len;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill_result();
        result = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                result[(r*N+c)*W +: W] = elem[r][c];
    endtask

    task automatic rand_elems();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                elem[r][c] = 16'($urandom);
    endtask

    // Expected byte stream straight from the element matrix
    task automatic build_exp(input int sz);
        logic [7:0] x;
        bit         ok;
        x  = 8'h00;
        ok = (sz >= 1) && (sz <= N);
        exp_q.delete();
`ifdef MATMUL_RESULT_TX_FRAME_EN
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(sz));
`endif
        if (ok) begin
            for (int r = 0; r < sz; r++)
                for (int c = 0; c < sz; c++) begin
                    exp_q.push_back(elem[r][c][15:8]);
                    exp_q.push_back(elem[r][c][7:0]);
                    x = x ^ elem[r][c][15:8] ^ elem[r][c][7:0];
                end
`ifdef MATMUL_RESULT_TX_FRAME_EN
            exp_q.push_back(x);
`endif
        end
    endtask

    task automatic pulse_start(input int sz, input bit do_clr, output int c0);
        matrix_size = 4'(sz);
        start = 1'b1;
        clr   = do_clr;
        step();
        start = 1'b0;
        clr   = 1'b0;
        c0    = cyc;
        // scramble inputs: the running sequence must use its captured copy
        for (int i = 0; i < N*N; i++) result[i*W +: W] = 16'($urandom);
        matrix_size = 4'($urandom);
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (tx_busy && n < 200) begin step(); n++; end
    endtask

    task automatic run_seq(input string nm, input int sz, input int blen, input int ign);
        int  c0, dc, n;
        bit  ok;
        ok = (sz >= 1) && (sz <= N);
        wait_tx_idle();
        busy_len  = blen;
        ign_limit = ign;
        build_exp(sz);
        fill_result();
        pulse_start(sz, 1'b1, c0);
        chk({nm, ":busy_after_start"}, 32'(busy), 32'd1);
        if (ok) chk({nm, ":size_err_cleared"}, 32'(size_err), 32'd0);
        n = 0;
        while (!done && n < BUDGET) begin step(); n++; end
        dc = cyc;
        chk({nm, ":done_seen"}, 32'(done), 32'd1);
        chk({nm, ":busy_low_at_done"}, 32'(busy), 32'd0);
        chk({nm, ":size_err"}, 32'(size_err), ok ? 32'd0 : 32'd1);
        step();
        chk({nm, ":done_one_cycle"}, 32'(done), 32'd0);
        chk({nm, ":byte_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size())
                chk($sformatf("%s:byte%0d", nm, i), 32'(rx_q[i]), 32'(exp_q[i]));
        chk({nm, ":tx_start_count"}, 32'(st_q.size()), 32'(exp_q.size() + ign));
        chk({nm, ":tx_start_pulse_width"}, 32'(pulse_viol), 32'd0);
        chk({nm, ":tx_data_stable"}, 32'(stable_viol), 32'd0);
        chk({nm, ":done_protocol"}, 32'(done_viol), 32'd0);
        if (exp_q.size() == 0)
            chk({nm, ":done_cycle"}, 32'(dc), 32'(c0 + 1));
        else if (st_q.size() > 0)
            chk({nm, ":first_tx_start_cycle"}, 32'(st_q[0]), 32'(c0 + 1));
    endtask

    initial begin
        int c0, n;
        rst_n       = 1'b0;
        start       = 1'b0;
        matrix_size = 4'd0;
        result      = '0;
        repeat (3) step();
        chk("reset:tx_data", 32'(tx_data), 32'h00);
        chk("reset:tx_start", 32'(tx_start), 32'd0);
        chk("reset:busy", 32'(busy), 32'd0);
        chk("reset:done", 32'(done), 32'd0);
        chk("reset:size_err", 32'(size_err), 32'd0);
        rst_n = 1'b1;
        step();

        // size 2, element (r,c) = 0x1000 + r*3+c
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                elem[r][c] = 16'h1000 + 16'(r*3 + c);
        run_seq("size2", 2, 3, 0);

        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                elem[r][c] = 16'hBEEF;
        run_seq("beef", 3, 10, 0);

        // first tx_start ignored by uart_tx: retry with the same byte
        rand_elems();
        run_seq("retry", 1, 2, 1);
        if (st_q.size() >= 2) begin
            chk("retry:interval", 32'(st_q[1] - st_q[0]), 32'(ACK_TO + 1));
            chk("retry:same_byte", 32'(sd_q[1]), 32'(sd_q[0]));
        end else begin
            chk("retry:reissue_seen", 32'(st_q.size()), 32'd2);
        end

        run_seq("size0", 0, 2, 0);
        run_seq("size5", 5, 2, 0);
        rand_elems();
        run_seq("after_err", 2, 2, 0);

        for (int k = 0; k < 4; k++) begin
            rand_elems();
            run_seq($sformatf("rand%0d", k), int'($urandom_range(1, 3)), int'($urandom_range(1, 6)), 0);
        end

        // second start mid-sequence is dropped; reset after byte 5
        wait_tx_idle();
        rand_elems();
        busy_len  = 4;
        ign_limit = 0;
        build_exp(3);
        fill_result();
        pulse_start(3, 1'b1, c0);
        n = 0;
        while (rx_q.size() < 2 && n < BUDGET) begin step(); n++; end
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (rx_q.size() < 5 && n < BUDGET) begin step(); n++; end
        chk("midrst:reached_byte5", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < rx_q.size())
                chk($sformatf("midrst:byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
        rst_n = 1'b0;
        #1;
        chk("midrst:tx_data", 32'(tx_data), 32'h00);
        chk("midrst:tx_start", 32'(tx_start), 32'd0);
        chk("midrst:busy", 32'(busy), 32'd0);
        chk("midrst:done", 32'(done), 32'd0);
        chk("midrst:size_err", 32'(size_err), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        rand_elems();
        run_seq("post_reset", 3, 3, 0);

        // single element 0x12F0 (framed build expects A5 01 12 F0 E2)
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                elem[r][c] = 16'h0000;
        elem[0][0] = 16'h12F0;
        run_seq("single", 1, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/matmul_result_tx.md
# matmul_result_tx

Result-transmit sequencer for the UART matrix-multiplier. On a start pulse it latches the 144-bit product from the `Calculator` and serializes the active `matrix_size × matrix_size` elements, row-major and MSB byte first, into the `uart_tx` byte interface using its `start`/`busy` handshake. It replaces the ad-hoc result-indexing logic in the top level. It runs in the `bclk` domain and reports completion to `control_unit` so the FSM can leave `SEND_RESULT`.

## Interface
- `N_DIM`, 3: maximum matrix dimension. Storage holds `N_DIM*N_DIM` elements.
- `ELEM_W`, 16: result element width in bits. Must be a multiple of 8.
- `ACK_TO`, 15: cycles to wait for `tx_busy` rising before `tx_start` is re-issued.

Ports:
- `clk` input 1: the `bclk` domain clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle request to send the result. Ignored while `busy`=1.
- `result` input `N_DIM*N_DIM*ELEM_W`: element (r,c) occupies bits `[(r*N_DIM+c)*ELEM_W +: ELEM_W]`.
- `matrix_size` input 4: active dimension. Valid range is 1..`N_DIM`.
- `tx_busy` input 1: busy flag from `uart_tx`.
- `tx_data` output 8: byte to transmit.
- `tx_start` output 1: one-cycle transmit request.
- `busy` output 1: a sequence is in progress.
- `done` output 1: one-cycle pulse when a sequence ends.
- `size_err` output 1: set when `start` arrives with an invalid `matrix_size`. Held until the next accepted `start`.

## Operation
- Reset values: `tx_data`=0x00, `tx_start`=0, `busy`=0, `done`=0, `size_err`=0. FSM is in IDLE and all counters are 0.
- FSM states: IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH.
- IDLE→LOAD on `start`.
  - `result` and `matrix_size` are captured into internal registers.
  - `size_err` is cleared.
  - Later changes on the inputs have no effect on the sequence in progress.
- LOAD:
  - If the size is 0 or greater than `N_DIM`: set `size_err`, go to FINISH. No bytes are sent.
  - Otherwise: row=0, col=0, byte=0, go to ISSUE.
- ISSUE:
  - Drive `tx_data` with the selected byte.
  - Assert `tx_start` for exactly one cycle.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - On `tx_busy`=1, go to WAIT_DONE.
  - If `ACK_TO` cycles pass without `tx_busy`, return to ISSUE (retry with the same byte). Retries are unlimited.
- WAIT_DONE: on `tx_busy`=0, go to NEXT.
- NEXT:
  - Advance byte, then col, then row.
  - After the last byte of element (size-1, size-1), go to FINISH. Otherwise go to ISSUE.
- FINISH: pulse `done` for one cycle, then go to IDLE.
- Byte order within an element: byte 0 is `ELEM_W-1 : ELEM_W-8` (MSB first).
- Elements with row ≥ size or col ≥ size are skipped. They are never transmitted.
- Payload byte count is `size*size*ELEM_W/8`. With the defaults, size 3 gives 18 bytes and size 1 gives 2.
- A `start` that arrives while `busy`=1 is dropped and has no side effects.
- Reset asserted mid-sequence: all outputs return to their reset values immediately. A byte already accepted by `uart_tx` completes on the line; that is outside this block's scope.

## Timing
- `start` is sampled at edge 0. `busy` goes to 1 after edge 0.
- The first `tx_start` is high in cycle 2: edge 1 is LOAD, edge 2 is ISSUE.
- `tx_data` stays stable from ISSUE until WAIT_DONE exits.
- Minimum byte-to-byte interval: 4 cycles plus the `tx_busy` high time.
- `done` goes high in the same cycle that `busy` falls, and stays high for one cycle.
- If `tx_busy` is already 1 when ISSUE is entered, WAIT_ACK accepts it immediately. The block does not detect this case; upstream must guarantee `uart_tx` is idle on `start`.

## Configuration
- `MATMUL_RESULT_TX_FRAME_EN` defined: the payload is framed.
  - Header: sync byte 0xA5, then a byte equal to `{4'h0, matrix_size}`.
  - Trailer: XOR of all payload bytes.
  - Adds states HDR0, HDR1 and CHK. Size 3 sends 21 bytes.
  - When `size_err` is set, only the two header bytes are sent, then `done`.
- Undefined: raw payload only. Invalid size sends nothing.

## Structure
- Shared package `matmul_pkg` holds:
  - FSM state encoding;
  - the sync constant 0xA5;
  - `N_DIM` and `ELEM_W` defaults;
  - the element-index function `r*N_DIM+c`.
- One sub-module, `tx_byte_handshake`, implements ISSUE, WAIT_ACK and WAIT_DONE plus the timeout counter. It has a `req`/`ack` interface toward the sequencer.

## Test plan
- Size 2, element (r,c) = 0x1000 + (r*3+c) → bytes 10 00 10 01 10 03 10 04, then `done` pulse. Elements 2, 5, 6, 7, 8 are never sent.
- Size 3, all elements 0xBEEF, `uart_tx` model with busy=10 cycles → 18 bytes BE EF …, each `tx_start` exactly one cycle, `tx_data` stable while `tx_busy` is high.
- `uart_tx` model ignores the first `tx_start` → re-issue after 15 cycles with the same byte, then normal completion.
- Size 0 and size 5 → `size_err`=1, zero `tx_start`, `done` in cycle 2. Next valid `start` clears `size_err`.
- `start` re-pulsed mid-sequence, and `rst_n` low after byte 5 → second start ignored. After reset, all outputs are 0 and the next `start` begins again at element (0,0).
- With `MATMUL_RESULT_TX_FRAME_EN`, size 1, element 0x12F0 → bytes A5 01 12 F0 E2.
